// File: rtl/wb_scoreboard_pkg.sv
// Shared sizing and event payload types for the register-writeback scoreboard.
package wb_scoreboard_pkg;

  localparam int unsigned SB_CNT_W    = 2;
  localparam int unsigned SB_NREG     = 32;
  localparam int unsigned SB_REG_W    = 5;
  localparam int unsigned SB_RD_PORTS = 3;
  localparam int unsigned SB_INFL_W   = 3;

  // Write fields of a GPR-writing instruction (issue side or ws_to_rf side).
  typedef struct packed {
    logic                we;
    logic [SB_REG_W-1:0] dest;
  } sb_wr_t;

  // r0 is hardwired zero, so writes to it never count as events.
  function automatic logic sb_event(input logic valid, input sb_wr_t wr);
    return valid & wr.we & (wr.dest != '0);
  endfunction

endpackage

// File: rtl/wb_scoreboard_counter.sv
// Saturating up/down pending-write counter for one GPR, with synchronous clear.
module sb_counter
  import wb_scoreboard_pkg::*;
#(
  parameter int unsigned W = SB_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic ovf_c,
  output logic udf_c
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Simultaneous inc/dec cancel; saturation at either end raises a strobe.
  always_comb begin
    cnt_d = cnt_q;
    ovf_c = 1'b0;
    udf_c = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q == CNT_MAX) ovf_c = 1'b1;
      else                  cnt_d = cnt_q + W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) udf_c = 1'b1;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign nonzero = |cnt_q;

endmodule

// File: rtl/wb_scoreboard.sv
// Per-GPR pending-write scoreboard: decode RAW stall, busy vector, in-flight count, sticky errors.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            issue_valid,
  input  logic                            issue_we,
  input  logic [SB_REG_W-1:0]             issue_dest,
  input  logic                            retire_valid,
  input  logic                            retire_we,
  input  logic [SB_REG_W-1:0]             retire_dest,
  input  logic [SB_RD_PORTS-1:0]          rd_en,
  input  logic [SB_RD_PORTS*SB_REG_W-1:0] rd_addr,
  output logic                            ds_stall,
  output logic [SB_NREG-1:0]              busy_vec,
  output logic [SB_INFL_W-1:0]            inflight,
  output logic [1:0]                      sb_err
);

  sb_wr_t                 issue_wr;
  sb_wr_t                 retire_wr;
  logic                   issue_ev;
  logic                   retire_ev;
  logic [SB_NREG-1:0]     nonzero;
  logic [SB_NREG-1:0]     ovf;
  logic [SB_NREG-1:0]     udf;
  logic [SB_INFL_W-1:0]   inflight_d;
  logic [SB_REG_W-1:0]    src;

  assign issue_wr  = '{we: issue_we,  dest: issue_dest};
  assign retire_wr = '{we: retire_we, dest: retire_dest};

  // Flush squashes both the issuing instruction and the writeback stage.
  assign issue_ev  = !flush && sb_event(issue_valid,  issue_wr);
  assign retire_ev = !flush && sb_event(retire_valid, retire_wr);

  assign nonzero[0] = 1'b0;
  assign ovf[0]     = 1'b0;
  assign udf[0]     = 1'b0;

  for (genvar i = 1; i < SB_NREG; i++) begin : g_cnt
    sb_counter #(.W(SB_CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .inc     (issue_ev  && (issue_wr.dest  == SB_REG_W'(i))),
      .dec     (retire_ev && (retire_wr.dest == SB_REG_W'(i))),
      .nonzero (nonzero[i]),
      .ovf_c   (ovf[i]),
      .udf_c   (udf[i])
    );
  end

  assign busy_vec = nonzero;

  // Stall looks only at registered counters; a same-cycle retire does not release it.
  always_comb begin
    ds_stall = 1'b0;
    src      = '0;
    for (int p = 0; p < SB_RD_PORTS; p++) begin
      src = rd_addr[p*SB_REG_W +: SB_REG_W];
      if (rd_en[p] && (src != '0) && nonzero[src]) ds_stall = 1'b1;
    end
  end

  // Total in-flight writes, clamped to [0, 7].
  always_comb begin
    inflight_d = inflight;
    if (flush) begin
      inflight_d = '0;
    end else if (issue_ev && !retire_ev) begin
      if (inflight != '1) inflight_d = inflight + SB_INFL_W'(1);
    end else if (retire_ev && !issue_ev) begin
      if (inflight != '0) inflight_d = inflight - SB_INFL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      sb_err   <= '0;
    end else begin
      inflight <= inflight_d;
      sb_err   <= sb_err | {|udf, |ovf};
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard-driven bench for wb_scoreboard: reference model pushes expectations, DUT outputs are popped and compared.
module tb_wb_scoreboard;
  import wb_scoreboard_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_dest;
  logic        retire_valid, retire_we;
  logic [4:0]  retire_dest;
  logic [2:0]  rd_en;
  logic [14:0] rd_addr;
  logic        ds_stall;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;
  logic [1:0]  sb_err;

  typedef struct {
    logic        stall;
    logic [31:0] busy;
    logic [2:0]  inf;
    logic [1:0]  err;
  } exp_t;

  exp_t expq[$];
  int   cnt[32];
  int   inf_m;
  logic [1:0] err_m;
  int   n_vec;
  int   n_bad;

  wb_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_dest   (issue_dest),
    .retire_valid (retire_valid),
    .retire_we    (retire_we),
    .retire_dest  (retire_dest),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .ds_stall     (ds_stall),
    .busy_vec     (busy_vec),
    .inflight     (inflight),
    .sb_err       (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_stall(input int c[32]);
    logic s;
    s = 1'b0;
    for (int p = 0; p < 3; p++) begin
      logic [4:0] a;
      a = rd_addr[p*5 +: 5];
      if (rd_en[p] && a != 5'd0 && c[a] != 0) s = 1'b1;
    end
    return s;
  endfunction

  task automatic drive(input logic iv, input logic [4:0] id, input logic rv, input logic [4:0] rdst,
                       input logic fl, input logic [2:0] en, input logic [14:0] addr);
    issue_valid  = iv;
    issue_we     = 1'b1;
    issue_dest   = id;
    retire_valid = rv;
    retire_we    = 1'b1;
    retire_dest  = rdst;
    flush        = fl;
    rd_en        = en;
    rd_addr      = addr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0);
  endtask

  // One clock: check pre-edge stall, push post-edge expectation, clock, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    exp_t g;
    int   ncnt[32];
    int   ninf;
    logic [1:0] nerr;
    logic iss, ret;
    #1;
    check({tag, "/stall_pre"}, 32'(ds_stall), 32'(model_stall(cnt)));
    ncnt = cnt;
    ninf = inf_m;
    nerr = err_m;
    iss  = issue_valid && issue_we && issue_dest != 5'd0;
    ret  = retire_valid && retire_we && retire_dest != 5'd0;
    if (reset) begin
      foreach (ncnt[i]) ncnt[i] = 0;
      ninf = 0;
      nerr = 2'b00;
    end else if (flush) begin
      foreach (ncnt[i]) ncnt[i] = 0;
      ninf = 0;
    end else begin
      if (!(iss && ret && issue_dest == retire_dest)) begin
        if (iss) begin
          if (ncnt[issue_dest] == 3) nerr[0] = 1'b1;
          else ncnt[issue_dest]++;
        end
        if (ret) begin
          if (ncnt[retire_dest] == 0) nerr[1] = 1'b1;
          else ncnt[retire_dest]--;
        end
      end
      ninf = ninf + int'(iss) - int'(ret);
      if (ninf < 0) ninf = 0;
      if (ninf > 7) ninf = 7;
    end
    e.busy = '0;
    for (int i = 1; i < 32; i++) e.busy[i] = (ncnt[i] != 0);
    e.inf   = 3'(ninf);
    e.err   = nerr;
    e.stall = model_stall(ncnt);
    expq.push_back(e);
    @(posedge clk);
    cnt   = ncnt;
    inf_m = ninf;
    err_m = nerr;
    #1;
    if (expq.size() == 0) begin
      check({tag, "/queue_empty"}, 32'd0, 32'd1);
    end else begin
      g = expq.pop_front();
      check({tag, "/busy"},     busy_vec,         g.busy);
      check({tag, "/inflight"}, 32'(inflight),    32'(g.inf));
      check({tag, "/sb_err"},   32'(sb_err),      32'(g.err));
      check({tag, "/stall"},    32'(ds_stall),    32'(g.stall));
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    foreach (cnt[i]) cnt[i] = 0;
    inf_m = 0;
    err_m = 2'b00;
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    step("reset");
    check("reset/busy_zero", busy_vec, 32'd0);
    reset = 1'b0;

    // RAW stall on r5, released one cycle after retire
    drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0);   step("r5_issue");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b001, 15'd5);   step("r5_read");
    check("r5/busy_0x20", busy_vec, 32'h20);
    step("r5_hold");
    drive(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 3'b001, 15'd5);   step("r5_retire");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b001, 15'd5);   step("r5_free");
    check("r5/stall_released", 32'(ds_stall), 32'd0);

    // Overflow on r7, then drain
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0); step("r7_issue");
    end
    check("r7/sb_err_ovf", 32'(sb_err), 32'b01);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 3'b000, 15'd0); step("r7_retire");
    end
    check("r7/busy_clear", 32'(busy_vec[7]), 32'd0);

    // Same-cycle issue and retire of r9
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0);   step("r9_issue");
    drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 3'b000, 15'd0);   step("r9_both");
    drive(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 3'b000, 15'd0);   step("r9_retire");

    // r0 never tracked, r0 sources never stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'b111, 15'd0);   step("r0_issue");
    check("r0/busy_zero", busy_vec, 32'd0);

    // Flush with concurrent issue of r8
    drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0);   step("fl_r3");
    drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0);   step("fl_r4");
    drive(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 3'b111, {5'd6, 5'd4, 5'd3}); step("fl_r6");
    drive(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 3'b001, 15'd8);   step("fl_flush");
    check("flush/busy_zero", busy_vec, 32'd0);
    idle();                                              step("fl_after");

    // Underflow on r12 survives flush, cleared by reset
    reset = 1'b1;                                        step("uf_reset");
    reset = 1'b0;
    drive(1'b0, 5'd0, 1'b1, 5'd12, 1'b0, 3'b000, 15'd0);  step("uf_retire");
    check("uf/sb_err", 32'(sb_err), 32'b10);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'b000, 15'd0);   step("uf_flush");
    idle();
    reset = 1'b1;                                        step("uf_clear");
    reset = 1'b0;

    // Random traffic on a few registers with occasional flush
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
            1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
            {5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4))});
      issue_we  = 1'($urandom_range(0, 3) != 0);
      retire_we = 1'($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
